// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, instruction fields,
// ALU operations, datapath select codes and the decoder result struct.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_LUI = 4'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] PC_SEL_PC4 = 4'b0001;
  localparam logic [3:0] PC_SEL_BR  = 4'b0010;
  localparam logic [3:0] PC_SEL_JMP = 4'b0100;
  localparam logic [3:0] PC_SEL_RS  = 4'b1000;

  localparam logic [3:0] ALUB_RT   = 4'b0001;
  localparam logic [3:0] ALUB_SEXT = 4'b0010;
  localparam logic [3:0] ALUB_ZEXT = 4'b0100;
  localparam logic [3:0] ALUB_HI   = 4'b1000;

  localparam logic [4:0] WA_RD  = 5'b00001;
  localparam logic [4:0] WA_RT  = 5'b00010;
  localparam logic [4:0] WA_R31 = 5'b00100;

  localparam logic [2:0] WD_ALU  = 3'b001;
  localparam logic [2:0] WD_MEM  = 3'b010;
  localparam logic [2:0] WD_LINK = 3'b100;

  typedef struct packed {
    cls_e       cls;
    alu_op_e    alu_op;
    logic [3:0] alub_sel;
    logic [4:0] wa_sel;
    logic [2:0] wd_sel;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control <-> datapath/memory bundle: instruction fields and acks in, strobes and selects out.
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_we;
  logic       pc_we;
  logic       reg_we;
  logic       trap;
  logic [3:0] pc_sel;
  logic [3:0] alub_sel;
  logic [4:0] wa_sel;
  logic [2:0] wd_sel;
  logic [3:0] alu_op;

  modport master (
    input  opcode, funct, alu_zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, trap,
           pc_sel, alub_sel, wa_sel, wd_sel, alu_op
  );

  modport slave (
    output opcode, funct, alu_zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, trap,
           pc_sel, alub_sel, wa_sel, wd_sel, alu_op
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder: instruction class plus the ALU op and
// select codes the FSM forwards in the state that consumes them.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CL_ALU_R, alu_op: ALU_ADD, alub_sel: ALUB_RT,
            wa_sel: WA_RD, wd_sel: WD_ALU, illegal: 1'b0};
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_SLL:  dec.alu_op = ALU_SLL;
          FN_JR:   dec.cls    = CL_JR;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDIU: begin
        dec.cls = CL_ALU_I; dec.alub_sel = ALUB_SEXT; dec.wa_sel = WA_RT;
      end
      OP_ANDI: begin
        dec.cls = CL_ALU_I; dec.alu_op = ALU_AND; dec.alub_sel = ALUB_ZEXT; dec.wa_sel = WA_RT;
      end
      OP_ORI: begin
        dec.cls = CL_ALU_I; dec.alu_op = ALU_OR; dec.alub_sel = ALUB_ZEXT; dec.wa_sel = WA_RT;
      end
      OP_LUI: begin
        dec.cls = CL_ALU_I; dec.alu_op = ALU_LUI; dec.alub_sel = ALUB_HI; dec.wa_sel = WA_RT;
      end
      OP_LW: begin
        dec.cls = CL_LW; dec.alub_sel = ALUB_SEXT; dec.wa_sel = WA_RT; dec.wd_sel = WD_MEM;
      end
      OP_SW: begin
        dec.cls = CL_SW; dec.alub_sel = ALUB_SEXT;
      end
      OP_BEQ: begin
        dec.cls = CL_BEQ; dec.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        dec.cls = CL_BNE; dec.alu_op = ALU_SUB;
      end
      OP_J:   dec.cls = CL_J;
      OP_JAL: begin
        dec.cls = CL_JAL; dec.wa_sel = WA_R31; dec.wd_sel = WD_LINK;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-wait
// timeout and a sticky TRAP state. Only the state and wait counter are registered.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic           clk,
  input  logic           resetn,
  mc_ctrl_fsm_if.master  bus
);

  localparam bit             TO_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  dec_t            dec;

  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, trap;
  logic [3:0] pc_sel, alub_sel, alu_op;
  logic [4:0] wa_sel;
  logic [2:0] wd_sel;
  logic       to_hit;

  mc_decode u_dec (.opcode(bus.opcode), .funct(bus.funct), .dec(dec));

  // to_hit marks the last allowed wait cycle; an ack in that same cycle still wins.
  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0;
    ir_we    = 1'b0; pc_we    = 1'b0; reg_we  = 1'b0; trap = 1'b0;
    pc_sel   = '0;   alub_sel = '0;   alu_op  = '0;
    wa_sel   = '0;   wd_sel   = '0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_we = 1'b1; pc_we = 1'b1; pc_sel = PC_SEL_PC4;
          state_d = ST_DECODE;
        end else if (to_hit) state_d = ST_TRAP;
        else cnt_d = cnt_q + TO_W'(1);
      end
      ST_DECODE: begin
        if (dec.illegal) state_d = ST_TRAP;
        else begin
          case (dec.cls)
            CL_J: begin
              pc_we = 1'b1; pc_sel = PC_SEL_JMP; state_d = ST_FETCH;
            end
            CL_JAL: begin
              pc_we = 1'b1; pc_sel = PC_SEL_JMP;
              reg_we = 1'b1; wa_sel = dec.wa_sel; wd_sel = dec.wd_sel;
              state_d = ST_FETCH;
            end
            CL_JR: begin
              pc_we = 1'b1; pc_sel = PC_SEL_RS; state_d = ST_FETCH;
            end
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        alu_op = dec.alu_op; alub_sel = dec.alub_sel;
        case (dec.cls)
          CL_BEQ, CL_BNE: begin
            if (bus.alu_zero == (dec.cls == CL_BEQ)) begin
              pc_we = 1'b1; pc_sel = PC_SEL_BR;
            end
            state_d = ST_FETCH;
          end
          CL_LW, CL_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        // Address operands stay driven so the request is stable until ack.
        dmem_req = 1'b1; dmem_we = (dec.cls == CL_SW);
        alu_op = dec.alu_op; alub_sel = dec.alub_sel;
        if (bus.dmem_ack) state_d = (dec.cls == CL_SW) ? ST_FETCH : ST_WB;
        else if (to_hit) state_d = ST_TRAP;
        else cnt_d = cnt_q + TO_W'(1);
      end
      ST_WB: begin
        reg_we = 1'b1; wa_sel = dec.wa_sel; wd_sel = dec.wd_sel;
        state_d = ST_FETCH;
      end
      ST_TRAP: trap = 1'b1;
      default: state_d = ST_TRAP;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign bus.imem_req = resetn & imem_req;
  assign bus.dmem_req = resetn & dmem_req;
  assign bus.dmem_we  = resetn & dmem_we;
  assign bus.ir_we    = resetn & ir_we;
  assign bus.pc_we    = resetn & pc_we;
  assign bus.reg_we   = resetn & reg_we;
  assign bus.trap     = resetn & trap;
  assign bus.pc_sel   = resetn ? pc_sel   : '0;
  assign bus.alub_sel = resetn ? alub_sel : '0;
  assign bus.wa_sel   = resetn ? wa_sel   : '0;
  assign bus.wd_sel   = resetn ? wd_sel   : '0;
  assign bus.alu_op   = resetn ? alu_op   : '0;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle output vectors against hand-computed
// values, plus a negedge monitor for the select-vector one-hot rule.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  mc_ctrl_fsm_if bus();

  mc_ctrl_fsm #(.TIMEOUT(4), .TO_W(8)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  // flag order: {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, trap}
  localparam logic [6:0] F_IREQ = 7'b1000000;
  localparam logic [6:0] F_DREQ = 7'b0100000;
  localparam logic [6:0] F_DWE  = 7'b0010000;
  localparam logic [6:0] F_IRW  = 7'b0001000;
  localparam logic [6:0] F_PCW  = 7'b0000100;
  localparam logic [6:0] F_RWE  = 7'b0000010;
  localparam logic [6:0] F_TRAP = 7'b0000001;

  function automatic logic [31:0] ev(input logic [6:0] f, input logic [3:0] pc,
                                     input logic [3:0] ab, input logic [4:0] wa,
                                     input logic [2:0] wd, input logic [3:0] op);
    return {5'd0, f, pc, ab, wa, wd, op};
  endfunction

  function automatic logic [31:0] outs();
    return {5'd0, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we,
            bus.reg_we, bus.trap, bus.pc_sel, bus.alub_sel, bus.wa_sel, bus.wd_sel, bus.alu_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic expect_o(input string tag, input logic [31:0] e);
    #1; chk(tag, outs(), e);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.alu_zero = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    expect_o("rst_outs", 32'd0);
    cyc(); cyc();
    resetn = 1'b1;
  endtask

  task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op; bus.funct = fn; bus.imem_ack = 1'b1;
    expect_o({tag, "_fetch"}, ev(F_IREQ | F_IRW | F_PCW, 4'b0001, 4'b0, 5'b0, 3'b0, 4'd0));
    cyc();
  endtask

  task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [3:0] aop, input logic [3:0] ab, input logic [4:0] wa);
    fetch(tag, op, fn);
    expect_o({tag, "_dec"}, 32'd0); cyc();
    expect_o({tag, "_exe"}, ev(7'b0, 4'b0, ab, 5'b0, 3'b0, aop)); cyc();
    expect_o({tag, "_wb"}, ev(F_RWE, 4'b0, 4'b0, wa, 3'b001, 4'd0)); cyc();
  endtask

  task automatic run_br(input string tag, input logic [5:0] op, input logic z, input logic taken);
    fetch(tag, op, 6'h00);
    expect_o({tag, "_dec"}, 32'd0); cyc();
    bus.alu_zero = z;
    expect_o({tag, "_exe"}, ev(taken ? F_PCW : 7'b0, taken ? 4'b0010 : 4'b0, 4'b0001,
                               5'b0, 3'b0, 4'd1));
    cyc();
  endtask

  task automatic run_j(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [6:0] f, input logic [3:0] pc, input logic [4:0] wa,
                       input logic [2:0] wd);
    fetch(tag, op, fn);
    expect_o({tag, "_dec"}, ev(f, pc, 4'b0, wa, wd, 4'd0)); cyc();
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      chk("oh_pc", 32'(bus.pc_we ? $onehot(bus.pc_sel) : (bus.pc_sel == 4'd0)), 32'd1);
      chk("oh_wa", 32'(bus.reg_we ? ($onehot(bus.wa_sel) && bus.wa_sel[4:3] == 2'b00)
                                  : (bus.wa_sel == 5'd0)), 32'd1);
      chk("oh_wd", 32'(bus.reg_we ? $onehot(bus.wd_sel) : (bus.wd_sel == 3'd0)), 32'd1);
      chk("oh_ab", 32'($onehot0(bus.alub_sel)), 32'd1);
      chk("dwe_q", 32'(!bus.dmem_we || bus.dmem_req), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    #3;
    do_reset();

    // ALU table: tag, opcode, funct, alu_op, alub_sel, wa_sel
    run_alu("addu",  6'h00, 6'h21, 4'd0, 4'b0001, 5'b00001);
    run_alu("subu",  6'h00, 6'h23, 4'd1, 4'b0001, 5'b00001);
    run_alu("and",   6'h00, 6'h24, 4'd2, 4'b0001, 5'b00001);
    run_alu("or",    6'h00, 6'h25, 4'd3, 4'b0001, 5'b00001);
    run_alu("xor",   6'h00, 6'h26, 4'd4, 4'b0001, 5'b00001);
    run_alu("slt",   6'h00, 6'h2A, 4'd5, 4'b0001, 5'b00001);
    run_alu("sll",   6'h00, 6'h00, 4'd6, 4'b0001, 5'b00001);
    run_alu("addiu", 6'h09, 6'h3F, 4'd0, 4'b0010, 5'b00010);
    run_alu("andi",  6'h0C, 6'h00, 4'd2, 4'b0100, 5'b00010);
    run_alu("ori",   6'h0D, 6'h00, 4'd3, 4'b0100, 5'b00010);
    run_alu("lui",   6'h0F, 6'h00, 4'd7, 4'b1000, 5'b00010);

    // LW with ack on the 4th MEM cycle (the last one the timeout allows)
    fetch("lw", 6'h23, 6'h00);
    expect_o("lw_dec", 32'd0); cyc();
    expect_o("lw_exe", ev(7'b0, 4'b0, 4'b0010, 5'b0, 3'b0, 4'd0)); cyc();
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ack = (i == 3);
      expect_o("lw_mem", ev(F_DREQ, 4'b0, 4'b0010, 5'b0, 3'b0, 4'd0)); cyc();
    end
    bus.dmem_ack = 1'b0;
    expect_o("lw_wb", ev(F_RWE, 4'b0, 4'b0, 5'b00010, 3'b010, 4'd0)); cyc();

    fetch("sw", 6'h2B, 6'h00);
    expect_o("sw_dec", 32'd0); cyc();
    expect_o("sw_exe", ev(7'b0, 4'b0, 4'b0010, 5'b0, 3'b0, 4'd0)); cyc();
    bus.dmem_ack = 1'b1;
    expect_o("sw_mem", ev(F_DREQ | F_DWE, 4'b0, 4'b0010, 5'b0, 3'b0, 4'd0)); cyc();
    bus.dmem_ack = 1'b1;

    run_br("beq_t", 6'h04, 1'b1, 1'b1);
    run_br("beq_n", 6'h04, 1'b0, 1'b0);
    run_br("bne_t", 6'h05, 1'b0, 1'b1);
    run_br("bne_n", 6'h05, 1'b1, 1'b0);
    bus.alu_zero = 1'b0;

    run_j("j",   6'h02, 6'h00, F_PCW, 4'b0100, 5'b0, 3'b0);
    run_j("jal", 6'h03, 6'h00, F_PCW | F_RWE, 4'b0100, 5'b00100, 3'b100);
    run_j("jr",  6'h00, 6'h08, F_PCW, 4'b1000, 5'b0, 3'b0);

    // Illegal opcode: trap is sticky and acks are ignored afterwards
    fetch("ill", 6'h3F, 6'h00);
    expect_o("ill_dec", 32'd0); cyc();
    for (int i = 0; i < 3; i++) begin
      bus.dmem_ack = 1'b1;
      expect_o("ill_trap", ev(F_TRAP, 4'b0, 4'b0, 5'b0, 3'b0, 4'd0)); cyc();
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_o("to_wait", ev(F_IREQ, 4'b0, 4'b0, 5'b0, 3'b0, 4'd0)); cyc();
    end
    expect_o("to_trap", ev(F_TRAP, 4'b0, 4'b0, 5'b0, 3'b0, 4'd0)); cyc();
    expect_o("to_hold", ev(F_TRAP, 4'b0, 4'b0, 5'b0, 3'b0, 4'd0));

    // Reset asserted between clock edges while a data request is pending
    do_reset();
    fetch("rlw", 6'h23, 6'h00);
    expect_o("rlw_dec", 32'd0); cyc();
    cyc();
    bus.dmem_ack = 1'b0;
    expect_o("rlw_mem", ev(F_DREQ, 4'b0, 4'b0010, 5'b0, 3'b0, 4'd0));
    resetn = 1'b0;
    expect_o("rst_async", 32'd0);
    cyc(); cyc();
    bus.imem_ack = 1'b0;
    resetn = 1'b1;
    expect_o("rst_rel", ev(F_IREQ, 4'b0, 4'b0, 5'b0, 3'b0, 4'd0));
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
